mul_add_seq: RTL and testbench
==============================

# mul_add_seq

Sequential multiply-add unit: computes m = x·y + c over M clock cycles with one shift-and-add step per multiplier bit, trading the single-cycle array of the combinational multiply-adder for one (N+M)-bit adder. Generalised in operand widths N and M, with an optional integer (two's complement) mode alongside naturals. Sits as a datapath slave behind a start/ready/valid handshake, driven by a controller that issues one operation at a time.

## Interface
- N, default 4: width of the multiplicand x and the addend c (≥ 2).
- M, default 4: width of the multiplier y, which is also the latency in RUN cycles (≥ 2).
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only on an edge where ready=1.
- x  input  N  multiplicand; sampled with start.
- y  input  M  multiplier; sampled with start.
- c  input  N  addend; sampled with start.
- is_int  input  1  only when MUL_ADD_SIGNED_EN is defined: 1 selects integer operands, 0 selects naturals; sampled with start.
- ready  output  1  unit accepts start (state IDLE or DONE).
- valid  output  1  m holds the result of the last accepted operation.
- m  output  N+M  result register.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: ready=1, valid=0. If start=1, latch x, y, c and is_int; set acc = c extended to N+M bits (zero-extended for naturals, sign-extended for integers); set cnt=0; go to RUN.
- RUN: ready=0. Each edge: if y_reg[cnt]=1, acc += x_reg extended to N+M bits and shifted left by cnt; otherwise acc is unchanged. Then cnt++.
  - Integer mode, cnt=M-1: the term is subtracted instead of added, because the MSB of y has negative weight.
  - At cnt=M-1: go to DONE and load m from the final acc value.
- DONE: ready=1, valid=1, m stable. A start behaves as in IDLE: the unit restarts and valid drops to 0 on that edge; m keeps its old value until the new result loads.
- start while in RUN: ignored, with no effect on state or operands.
- Width rules: the result always fits in N+M bits, with no overflow or carry output.
  - Naturals: (2^N−1)(2^M−1)+2^N−1 < 2^(N+M).
  - Integers: the range is [−2^(N+M−2)−2^(N−1), 2^(N+M−2)+2^(N−1)−1].
  - All arithmetic is modulo 2^(N+M).
- Inputs may change freely except on the edge where start is accepted.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, ready=1, valid=0, m=0, acc=0, cnt=0.
- Latency: start accepted at edge k gives valid=1 and m updated right after edge k+M. Throughput is one operation per M+1 edges; a start issued on the first DONE cycle is accepted at edge k+M+1.
- Reset during RUN aborts the operation: no partial result reaches m, and the unit returns to IDLE.
- ready and valid are decoded from state only, with no combinational path from start.

## Configuration
- MUL_ADD_SIGNED_EN defined:
  - The is_int port exists.
  - Integer mode uses sign extension of c and x and subtracts the MSB partial product.
  - Natural mode is identical to the build without the macro.
- Macro undefined:
  - No is_int port.
  - Natural numbers only, zero extension throughout.
  - No subtract path is built.

## Structure
- Package mul_add_pkg:
  - State encoding constants IDLE/RUN/DONE (2 bits).
  - A width helper for the cnt width, $clog2(M).
- One sub-module: add, the team's parametrised adder, instanced with width N+M.
  - In the subtract step, operand y is the inverted term and c_in=1.
  - c_out and ow are left unconnected.
- The controller and registers stay in mul_add_seq.

## Test plan
All cases use N=M=4.
- Reset, then idle: ready=1, valid=0, m=0x00.
- Naturals x=15, y=15, c=15 -> valid after 4 RUN edges, m=0xF0 (240); x=0, y=9, c=5 -> m=0x05.
- Integer mode (macro defined, is_int=1):
  - x=0x8, y=0x8, c=0x7 -> m=0x47 (71).
  - x=0x3, y=0xE, c=0xF -> m=0xF9 (−7).
  - The same operands with is_int=0 -> m=0x39 (57).
- start pulsed on the 2nd RUN edge with different operands -> ignored; m=0xF0 for the original 15·15+15.
- reset_n low on the 2nd RUN cycle -> immediate ready=1, valid=0, m=0x00; the next start computes normally.
- Back-to-back: start held high through DONE -> restart on the first DONE edge, valid low for 4 cycles, and the old m stays stable until the new result loads.

Source files
------------

// File: rtl/mul_add_pkg.sv
// Shared types and helpers for the sequential multiply-add unit.
// Contents: state encoding (IDLE/RUN/DONE, 2 bits) and the step-counter width helper.
// Optional feature macro used by the files that import this package: MUL_ADD_SIGNED_EN.
package mul_add_pkg;

  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned M_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter width: $clog2(M), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mul_add_seq_if.sv
// Start/ready/valid handshake bundle between the controller and the multiply-add unit.
// Signals: start, x[N], y[M], c[N], is_int (MUL_ADD_SIGNED_EN only) from the master;
//          ready, valid, m[N+M] from the slave.
interface mul_add_seq_if #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 4
) ();

  logic             start;
  logic [N-1:0]     x;
  logic [M-1:0]     y;
  logic [N-1:0]     c;
`ifdef MUL_ADD_SIGNED_EN
  logic             is_int;
`endif
  logic             ready;
  logic             valid;
  logic [N+M-1:0]   m;

  modport master (
`ifdef MUL_ADD_SIGNED_EN
    output is_int,
`endif
    output start, x, y, c,
    input  ready, valid, m
  );

  modport slave (
`ifdef MUL_ADD_SIGNED_EN
    input  is_int,
`endif
    input  start, x, y, c,
    output ready, valid, m
  );

endinterface

// File: rtl/mul_add_seq_add.sv
// Parametrised ripple adder used as the single datapath adder.
// Ports: x, y (W-bit operands), c_in (carry in), s (W-bit sum),
//        c_out (carry out), ow (two's complement overflow).
module add #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         ow
);

  logic [W:0] w_full;

  assign w_full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c_in};
  assign s      = w_full[W-1:0];
  assign c_out  = w_full[W];
  // Overflow when both operands share a sign that the sum does not.
  assign ow     = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);

endmodule

// File: rtl/mul_add_seq.sv
// Sequential multiply-add: m = x*y + c, one shift-and-add step per multiplier bit.
// Ports: clock, reset_n (async, active-low), bus (mul_add_seq_if.slave).
// Optional: MUL_ADD_SIGNED_EN adds is_int (two's complement operands; MSB step subtracts).
module mul_add_seq
  import mul_add_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned M = M_DEFAULT
) (
  input  logic          clock,
  input  logic          reset_n,
  mul_add_seq_if.slave  bus
);

  localparam int unsigned W  = N + M;
  localparam int unsigned CW = cnt_width(M);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_ready;
  logic            r_valid;
  logic [N-1:0]    r_x;
  logic [M-1:0]    r_y;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_m;
  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_x_ext;
  logic [W-1:0]    w_c_ext;
  logic [W-1:0]    w_term;
  logic [W-1:0]    w_add_b;
  logic            w_cin;
  logic [W-1:0]    w_sum;
  logic            w_unused_c_out;
  logic            w_unused_ow;
`ifdef MUL_ADD_SIGNED_EN
  logic            r_is_int;
  logic            w_sub;
`endif

  // Next state; start only counts when the unit is ready.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(M - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; ready/valid are registered decodes of the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != RUN);
      r_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand extension: sign extension only for integer operands.
`ifdef MUL_ADD_SIGNED_EN
  assign w_x_ext = r_is_int   ? {{M{r_x[N-1]}}, r_x}   : {{M{1'b0}}, r_x};
  assign w_c_ext = bus.is_int ? {{M{bus.c[N-1]}}, bus.c} : {{M{1'b0}}, bus.c};
  // The multiplier MSB carries negative weight in integer mode.
  assign w_sub   = r_is_int && (r_cnt == CW'(M - 1));
`else
  assign w_x_ext = {{M{1'b0}}, r_x};
  assign w_c_ext = {{M{1'b0}}, bus.c};
`endif

  assign w_term = w_x_ext << r_cnt;

  // Adder operand select: term, inverted term (+1 carry) for subtract, or zero.
  always_comb begin
    w_add_b = '0;
    w_cin   = 1'b0;
    if (r_y[r_cnt]) begin
`ifdef MUL_ADD_SIGNED_EN
      if (w_sub) begin
        w_add_b = ~w_term;
        w_cin   = 1'b1;
      end else begin
        w_add_b = w_term;
      end
`else
      w_add_b = w_term;
`endif
    end
  end

  add #(.W(W)) u_add (
    .x     (r_acc),
    .y     (w_add_b),
    .c_in  (w_cin),
    .s     (w_sum),
    .c_out (w_unused_c_out),
    .ow    (w_unused_ow)
  );

  // Operand latch, accumulator, step counter and result register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_m      <= '0;
`ifdef MUL_ADD_SIGNED_EN
      r_is_int <= 1'b0;
`endif
    end else if (w_accept) begin
      r_x      <= bus.x;
      r_y      <= bus.y;
      r_acc    <= w_c_ext;
      r_cnt    <= '0;
`ifdef MUL_ADD_SIGNED_EN
      r_is_int <= bus.is_int;
`endif
    end else if (r_state == RUN) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_m <= w_sum;
      end
    end
  end

  assign bus.ready = r_ready;
  assign bus.valid = r_valid;
  assign bus.m     = r_m;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed testbench for mul_add_seq with N=M=4.
// Integer-mode vectors are included when MUL_ADD_SIGNED_EN is defined.
module tb_mul_add_seq;

  localparam int unsigned N = 4;
  localparam int unsigned M = 4;

  logic clock;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  logic tb_unused_is_int;

  mul_add_seq_if #(.N(N), .M(M)) bus ();

  mul_add_seq #(.N(N), .M(M)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_int(input logic si);
`ifdef MUL_ADD_SIGNED_EN
    bus.is_int = si;
`else
    tb_unused_is_int = si;
`endif
  endtask

  // One operation; poke >= 0 pulses start with junk operands before that RUN edge.
  task automatic run_op(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [3:0] c, input logic si, input logic [7:0] exp,
                        input int poke);
    @(negedge clock);
    bus.start = 1'b1;
    bus.x = x; bus.y = y; bus.c = c;
    set_int(si);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check({tag, "/ready_run"}, 32'(bus.ready), 32'd0);
    check({tag, "/valid_run"}, 32'(bus.valid), 32'd0);
    for (int i = 0; i < int'(M); i++) begin
      if (i == poke) begin
        @(negedge clock);
        bus.start = 1'b1;
        bus.x = 4'h1; bus.y = 4'h1; bus.c = 4'h0;
        set_int(1'b0);
      end
      @(posedge clock); #1;
      bus.start = 1'b0;
      if (i < int'(M) - 1) begin
        check({tag, "/valid_low"}, 32'(bus.valid), 32'd0);
      end else begin
        check({tag, "/valid"}, 32'(bus.valid), 32'd1);
        check({tag, "/ready"}, 32'(bus.ready), 32'd1);
        check({tag, "/m"}, 32'(bus.m), 32'(exp));
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tb_unused_is_int = 1'b0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.x = '0; bus.y = '0; bus.c = '0;
    set_int(1'b0);

    // Reset state, then idle.
    #12;
    check("rst/ready", 32'(bus.ready), 32'd1);
    check("rst/valid", 32'(bus.valid), 32'd0);
    check("rst/m", 32'(bus.m), 32'h00);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("idle/ready", 32'(bus.ready), 32'd1);
    check("idle/valid", 32'(bus.valid), 32'd0);
    check("idle/m", 32'(bus.m), 32'h00);

    // Naturals.
    run_op("nat_max", 4'hF, 4'hF, 4'hF, 1'b0, 8'hF0, -1);
    run_op("nat_zero_x", 4'h0, 4'h9, 4'h5, 1'b0, 8'h05, -1);
    run_op("nat_3_14_15", 4'h3, 4'hE, 4'hF, 1'b0, 8'h39, -1);
    run_op("nat_8_8_7", 4'h8, 4'h8, 4'h7, 1'b0, 8'h47, -1);

`ifdef MUL_ADD_SIGNED_EN
    // Integer mode.
    run_op("int_m8_m8_7", 4'h8, 4'h8, 4'h7, 1'b1, 8'h47, -1);
    run_op("int_3_m2_m1", 4'h3, 4'hE, 4'hF, 1'b1, 8'hF9, -1);
    run_op("int_m8_7_m8", 4'h8, 4'h7, 4'h8, 1'b1, 8'hC0, -1);
`endif

    // start during RUN is ignored.
    run_op("ignore_start", 4'hF, 4'hF, 4'hF, 1'b0, 8'hF0, 1);

    // Reset in the second RUN cycle aborts the operation.
    @(negedge clock);
    bus.start = 1'b1;
    bus.x = 4'hF; bus.y = 4'hF; bus.c = 4'hF;
    set_int(1'b0);
    @(posedge clock); #1;
    bus.start = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("abort/ready", 32'(bus.ready), 32'd1);
    check("abort/valid", 32'(bus.valid), 32'd0);
    check("abort/m", 32'(bus.m), 32'h00);
    @(negedge clock);
    reset_n = 1'b1;
    run_op("after_abort", 4'h5, 4'h3, 4'h2, 1'b0, 8'h11, -1);

    // Back-to-back: start held high through DONE.
    run_op("pre_b2b", 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, -1);
    @(negedge clock);
    bus.start = 1'b1;
    bus.x = 4'h5; bus.y = 4'h3; bus.c = 4'h2;
    set_int(1'b0);
    @(posedge clock); #1;
    bus.x = 4'hF; bus.y = 4'hF; bus.c = 4'hF;
    for (int i = 0; i < int'(M); i++) begin
      @(posedge clock); #1;
      if (i < int'(M) - 1) check("b2b_a/valid_low", 32'(bus.valid), 32'd0);
    end
    check("b2b_a/valid", 32'(bus.valid), 32'd1);
    check("b2b_a/m", 32'(bus.m), 32'h11);
    @(posedge clock); #1;
    bus.start = 1'b0;
    check("b2b_restart/valid", 32'(bus.valid), 32'd0);
    check("b2b_restart/m", 32'(bus.m), 32'h11);
    for (int i = 0; i < int'(M) - 1; i++) begin
      @(posedge clock); #1;
      check("b2b_run/valid", 32'(bus.valid), 32'd0);
      check("b2b_run/m_hold", 32'(bus.m), 32'h11);
    end
    @(posedge clock); #1;
    check("b2b_b/valid", 32'(bus.valid), 32'd1);
    check("b2b_b/m", 32'(bus.m), 32'hF0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
